// File: rtl/dw_fp_sqrt_inst.sv
// dw_fp_sqrt_inst: registered IEEE-754 square root with selectable rounding, latency 1.
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears z_inst and status_inst)
//   inst_a       operand {sign, exponent, fraction}
//   inst_rnd     rounding mode: 0 RNE, 1 RZ, 2 +inf, 3 -inf, 4 ties-up, 5 away; 6/7 as 0
//   z_inst       registered square root
//   status_inst  registered flags [0] zero [1] inf [2] invalid [5] inexact, others 0
//   Macro DW_FP_SQRT_IEEE_COMPLIANCE_EN: full subnormal and NaN handling; otherwise
//   subnormals flush to signed zero and positive NaNs read as +inf.
module dw_fp_sqrt_inst #(
    parameter int inst_sig_width = 23,
    parameter int inst_exp_width = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [inst_sig_width+inst_exp_width:0] inst_a,
    input  logic [2:0]                             inst_rnd,
    output logic [inst_sig_width+inst_exp_width:0] z_inst,
    output logic [7:0]                             status_inst
);
    localparam int SW = inst_sig_width;
    localparam int EW = inst_exp_width;
    localparam int QW = SW + 2;
    localparam int RW = 2 * QW;
    localparam logic [EW+1:0] BIAS = (EW+2)'((1 << (EW - 1)) - 1);
    localparam logic [SW+EW:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
    localparam logic [SW+EW:0] PINF = {1'b0, {EW{1'b1}}, {SW{1'b0}}};
`ifdef DW_FP_SQRT_IEEE_COMPLIANCE_EN
    localparam bit IEEE = 1'b1;
`else
    localparam bit IEEE = 1'b0;
`endif

    logic          sign;
    logic [EW-1:0] expo;
    logic [SW-1:0] frac;
    logic [SW:0]   sig_m;
    logic [EW+1:0] e_eff;
    logic [RW-1:0] rad;
    logic [QW-1:0] q;
    logic [QW+1:0] rem, trial;
    logic [SW:0]   q_sig;
    logic          odd, guard, sticky, inexact, inc, carry, zero_like;
    logic [EW-1:0] res_exp;
    logic [SW+EW:0] z_nxt;
    logic [7:0]    st_nxt;

    assign {sign, expo, frac} = inst_a;

`ifdef DW_FP_SQRT_IEEE_COMPLIANCE_EN
    // Subnormals: move the leading one up to the hidden-bit position and lower the exponent.
    always_comb begin
        sig_m = {1'b1, frac};
        e_eff = {2'b00, expo};
        if (expo == '0)
            for (int i = 0; i < SW; i++)
                if (frac[i]) begin
                    sig_m = (SW+1)'({1'b0, frac} << (SW - i));
                    e_eff = (EW+2)'(i - SW + 1);
                end
    end
`else
    assign sig_m = {1'b1, frac};
    assign e_eff = {2'b00, expo};
`endif

    // Odd unbiased exponent doubles the radicand so the exponent halves exactly.
    assign odd     = e_eff[0] ^ BIAS[0];
    assign rad     = odd ? {sig_m, {(SW+3){1'b0}}} : {1'b0, sig_m, {(SW+2){1'b0}}};
    assign res_exp = EW'((e_eff + BIAS) >> 1);

    // Restoring digit recurrence: one root bit per radicand bit pair.
    always_comb begin
        rem   = '0;
        q     = '0;
        trial = '0;
        for (int i = QW - 1; i >= 0; i--) begin
            rem   = {rem[QW-1:0], rad[2*i+1 -: 2]};
            trial = {q, 2'b01};
            q     = {q[QW-2:0], rem >= trial};
            rem   = q[0] ? rem - trial : rem;
        end
    end

    assign q_sig   = q[QW-1:1];
    assign guard   = q[0];
    assign sticky  = |rem;
    assign inexact = guard | sticky;
    assign inc     = (inst_rnd == 3'd1 || inst_rnd == 3'd3) ? 1'b0 :
                     (inst_rnd == 3'd2 || inst_rnd == 3'd5) ? inexact :
                     (inst_rnd == 3'd4) ? guard : guard & (sticky | q_sig[0]);
    assign carry   = inc & (&q_sig);
    assign zero_like = expo == '0 && (frac == '0 || !IEEE);

    always_comb begin
        z_nxt  = {1'b0, res_exp + EW'(carry), q_sig[SW-1:0] + SW'(inc)};
        st_nxt = {2'b00, inexact, 5'b00000};
        if (expo == '1 && frac == '0) begin
            z_nxt  = sign ? QNAN : PINF;
            st_nxt = sign ? 8'h04 : 8'h02;
        end else if (expo == '1) begin
            z_nxt  = (IEEE || sign) ? QNAN : PINF;
            st_nxt = IEEE ? (frac[SW-1] ? 8'h00 : 8'h04) : (sign ? 8'h04 : 8'h02);
        end else if (zero_like) begin
            z_nxt  = {sign, {(SW+EW){1'b0}}};
            st_nxt = 8'h01;
        end else if (sign) begin
            z_nxt  = QNAN;
            st_nxt = 8'h04;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            z_inst      <= '0;
            status_inst <= '0;
        end else begin
            z_inst      <= z_nxt;
            status_inst <= st_nxt;
        end
endmodule

// File: tb/tb_dw_fp_sqrt_inst.sv
// tb_dw_fp_sqrt_inst: random and directed check of dw_fp_sqrt_inst against a real-arithmetic model.
module tb_dw_fp_sqrt_inst;
`ifdef DW_FP_SQRT_IEEE_COMPLIANCE_EN
    localparam bit IEEE = 1'b1;
`else
    localparam bit IEEE = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_a = '0;
    logic [2:0]  inst_rnd = '0;
    logic [31:0] z_inst;
    logic [7:0]  status_inst;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] a;
        logic [2:0]  rnd;
        logic [31:0] z;
        logic [7:0]  st;
    } exp_t;
    exp_t pend[$];
    exp_t cur;

    dw_fp_sqrt_inst dut (
        .clk(clk), .rst_n(rst_n), .inst_a(inst_a), .inst_rnd(inst_rnd),
        .z_inst(z_inst), .status_inst(status_inst)
    );

    always #5 clk = ~clk;

    // Value-level model: decode, exact integer root via $sqrt plus correction, round by mode.
    function automatic void model(input logic [31:0] a, input logic [2:0] rnd,
                                  output logic [31:0] z, output logic [7:0] st);
        longint m, r, q, sig;
        int u, ex;
        bit g, sticky, up;
        bit s = a[31];
        int e = int'(a[30:23]);
        longint f = longint'(a[22:0]);
        z = 32'h7FC00000;
        st = 8'h04;
        if (e == 255) begin
            if (f == 0) begin
                if (!s) begin z = 32'h7F800000; st = 8'h02; end
            end else if (IEEE) begin
                st = a[22] ? 8'h00 : 8'h04;
            end else if (!s) begin
                z = 32'h7F800000; st = 8'h02;
            end
        end else if (e == 0 && (f == 0 || !IEEE)) begin
            z = {s, 31'b0};
            st = 8'h01;
        end else if (!s) begin
            m = (e == 0) ? f : f + 64'h800000;
            u = (e == 0) ? -126 : e - 127;
            while (m < 64'h800000) begin m = m * 2; u = u - 1; end
            if ((u & 1) != 0) begin m = m * 2; u = u - 1; end
            r = m << 25;
            q = longint'($sqrt(real'(r)));
            while (q * q > r) q = q - 1;
            while ((q + 1) * (q + 1) <= r) q = q + 1;
            sticky = (q * q != r);
            g = (q % 2) != 0;
            sig = q / 2;
            case (rnd)
                3'd1, 3'd3: up = 1'b0;
                3'd2, 3'd5: up = g || sticky;
                3'd4:       up = g;
                default:    up = g && (sticky || (sig % 2) != 0);
            endcase
            sig = sig + longint'(up);
            ex = u / 2 + 127;
            if (sig == 64'h1000000) begin sig = sig / 2; ex = ex + 1; end
            z = {1'b0, 8'(ex), 23'(sig)};
            st = (g || sticky) ? 8'h20 : 8'h00;
        end
    endfunction

    task automatic drive_rand();
        logic [31:0] a, z;
        logic [7:0]  st;
        logic [2:0]  rnd;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: a = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            4:          a = {1'b0, 8'($urandom_range(120, 135)), 23'($urandom)};
            5, 6:       a = $urandom;
            7:          a = {1'($urandom), 8'h00, 23'($urandom)};
            default:    a = {1'($urandom), 8'hFF, ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom)};
        endcase
        rnd = 3'($urandom);
        model(a, rnd, z, st);
        @(negedge clk);
        rst_n = 1'b1;
        inst_a = a;
        inst_rnd = rnd;
        pend.push_back('{a, rnd, z, st});
    endtask

    // Hand-computed vector: pins the model, then expects the literal from the DUT.
    task automatic directed(input logic [31:0] a, input logic [2:0] rnd,
                            input logic [31:0] zl, input logic [7:0] sl);
        logic [31:0] z;
        logic [7:0]  st;
        model(a, rnd, z, st);
        vectors++;
        if (z !== zl || st !== sl) begin
            miscompares++;
            $display("FAIL model a=%h rnd=%0d got z=%h st=%h want z=%h st=%h", a, rnd, z, st, zl, sl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        inst_a = a;
        inst_rnd = rnd;
        pend.push_back('{a, rnd, zl, sl});
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            vectors++;
            if (z_inst !== 32'h0 || status_inst !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_out z=%h st=%h want z=00000000 st=00", z_inst, status_inst);
            end
        end else if (pend.size() > 0) begin
            cur = pend.pop_front();
            vectors++;
            if (z_inst !== cur.z || status_inst !== cur.st) begin
                miscompares++;
                $display("FAIL result a=%h rnd=%0d got z=%h st=%h want z=%h st=%h",
                         cur.a, cur.rnd, z_inst, status_inst, cur.z, cur.st);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int r = 0; r < 4; r++) directed(32'h00000000, 3'(r), 32'h00000000, 8'h01);
        for (int r = 0; r < 4; r++) directed(32'h80000000, 3'(r), 32'h80000000, 8'h01);
        directed(32'h7F800000, 3'd0, 32'h7F800000, 8'h02);
        directed(32'hFF800000, 3'd0, 32'h7FC00000, 8'h04);
        directed(32'hBF800000, 3'd1, 32'h7FC00000, 8'h04);
        for (int r = 0; r < 8; r++) directed(32'h40800000, 3'(r), 32'h40000000, 8'h00);
        directed(32'h40000000, 3'd0, 32'h3FB504F3, 8'h20);
        directed(32'h40000000, 3'd1, 32'h3FB504F3, 8'h20);
        directed(32'h40000000, 3'd2, 32'h3FB504F4, 8'h20);
        directed(32'h40000000, 3'd3, 32'h3FB504F3, 8'h20);
        directed(32'h40000000, 3'd4, 32'h3FB504F3, 8'h20);
        directed(32'h40000000, 3'd5, 32'h3FB504F4, 8'h20);
        directed(32'h40000000, 3'd6, 32'h3FB504F3, 8'h20);
        directed(32'h3F800000, 3'd2, 32'h3F800000, 8'h00);
        directed(32'h407FFFFF, 3'd0, 32'h3FFFFFFF, 8'h20);
        directed(32'h407FFFFF, 3'd2, 32'h40000000, 8'h20);
`ifdef DW_FP_SQRT_IEEE_COMPLIANCE_EN
        directed(32'h00400000, 3'd0, 32'h1FB504F3, 8'h20);
        directed(32'h7FC00001, 3'd0, 32'h7FC00000, 8'h00);
        directed(32'h7F800001, 3'd0, 32'h7FC00000, 8'h04);
        directed(32'h80400000, 3'd0, 32'h7FC00000, 8'h04);
`else
        directed(32'h00400000, 3'd0, 32'h00000000, 8'h01);
        directed(32'h7FC00001, 3'd0, 32'h7F800000, 8'h02);
        directed(32'hFFC00000, 3'd0, 32'h7FC00000, 8'h04);
        directed(32'h80400000, 3'd0, 32'h80000000, 8'h01);
`endif
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                // New input sampled with reset low: its result must never appear.
                @(negedge clk);
                inst_a = 32'h40000000;
                rst_n = 1'b0;
                #1;
                vectors++;
                if (z_inst !== 32'h0 || status_inst !== 8'h00) begin
                    miscompares++;
                    $display("FAIL async_reset z=%h st=%h want z=00000000 st=00", z_inst, status_inst);
                end
                @(negedge clk);
                inst_a = $urandom;
            end
            drive_rand();
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (pend.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", pend.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
